// File: rtl/regfile_arb_pkg.sv
// Shared types and defaults for the register-file write arbiter.
// The LOCKED state only exists when REGFILE_ARB_LOCK_EN is defined.
package regfile_arb_pkg;

  localparam int unsigned REG_ADDR_W  = 2;
  localparam int unsigned REG_DATA_W  = 8;
  localparam int unsigned NUM_ENTRIES = 2 ** REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] addr_t;
  typedef logic [REG_DATA_W-1:0] data_t;

`ifdef REGFILE_ARB_LOCK_EN
  typedef enum logic [1:0] {IDLE, CLEAR, LOCKED} arb_state_e;
`else
  typedef enum logic [1:0] {IDLE, CLEAR} arb_state_e;
`endif

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Request channels, clear control and register-file write port of the arbiter.
// master = requester/register-file side, slave = arbiter.
interface regfile_write_arbiter_if
  import regfile_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = REG_ADDR_W,
  parameter int unsigned DATA_W  = REG_DATA_W
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      clear_req;
  logic                      clear_busy;
  logic [ID_W-1:0]           grant_id;
  logic [ADDR_W-1:0]         write_address;
  logic [DATA_W-1:0]         write_data;
  logic                      write_en;

  modport master (
    output req_valid, req_addr, req_data, req_lock, clear_req,
    input  req_ready, clear_busy, grant_id, write_address, write_data, write_en
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_lock, clear_req,
    output req_ready, clear_busy, grant_id, write_address, write_data, write_en
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr_i,
// returned as a one-hot grant and its index.
module rr_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned IdW = $clog2(N)
) (
  input  logic [N-1:0]   valid_i,
  input  logic [IdW-1:0] ptr_i,
  output logic [N-1:0]   grant_o,
  output logic [IdW-1:0] idx_o
);

  logic           found;
  logic [IdW-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IdW'((32'(ptr_i) + k) % N);
      if (!found && valid_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register-file write port with a built-in clear sequencer.
// Define REGFILE_ARB_LOCK_EN to let a requester hold its grant across beats via req_lock.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = REG_ADDR_W,
  parameter int unsigned DATA_W  = REG_DATA_W
) (
  input logic                    clock,
  input logic                    reset_n,
  regfile_write_arbiter_if.slave bus
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);
  typedef logic [ID_W-1:0] id_t;

  arb_state_e        state_q;
  id_t               ptr_q;
  id_t               grant_id_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              write_en_q;
  logic [ADDR_W-1:0] write_address_q;
  logic [DATA_W-1:0] write_data_q;
`ifdef REGFILE_ARB_LOCK_EN
  id_t               lock_id_q;
  logic              clear_pend_q;
`endif

  logic [ADDR_W-1:0] req_addr_arr [NUM_REQ];
  logic [DATA_W-1:0] req_data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_addr_arr[g] = bus.req_addr[g*ADDR_W +: ADDR_W];
    assign req_data_arr[g] = bus.req_data[g*DATA_W +: DATA_W];
  end

  logic [NUM_REQ-1:0] pick_onehot;
  id_t                pick_idx;
  id_t                ptr_next;

  rr_pick #(
    .N (NUM_REQ)
  ) u_rr_pick (
    .valid_i (bus.req_valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_onehot),
    .idx_o   (pick_idx)
  );

  assign ptr_next = (pick_idx == id_t'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

  logic [NUM_REQ-1:0] ready;
  id_t                acc_idx;
  logic               acc;

  // A same-cycle clear request wins over any requester in IDLE.
  always_comb begin
    ready   = '0;
    acc_idx = pick_idx;
    unique case (state_q)
      IDLE: begin
        if (!bus.clear_req) ready = pick_onehot;
      end
`ifdef REGFILE_ARB_LOCK_EN
      LOCKED: begin
        acc_idx          = lock_id_q;
        ready[lock_id_q] = bus.req_valid[lock_id_q];
      end
`endif
      default: ;
    endcase
    if (!reset_n) ready = '0;
  end

  assign acc = |ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      ptr_q           <= '0;
      grant_id_q      <= '0;
      clr_cnt_q       <= '0;
      write_en_q      <= 1'b0;
      write_address_q <= '0;
      write_data_q    <= '0;
`ifdef REGFILE_ARB_LOCK_EN
      lock_id_q       <= '0;
      clear_pend_q    <= 1'b0;
`endif
    end else begin
      write_en_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.clear_req) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
          end else if (acc) begin
            write_en_q      <= 1'b1;
            write_address_q <= req_addr_arr[acc_idx];
            write_data_q    <= req_data_arr[acc_idx];
            grant_id_q      <= acc_idx;
            ptr_q           <= ptr_next;
`ifdef REGFILE_ARB_LOCK_EN
            if (bus.req_lock[acc_idx]) begin
              state_q   <= LOCKED;
              lock_id_q <= acc_idx;
            end
`endif
          end
        end
        CLEAR: begin
          write_en_q      <= 1'b1;
          write_address_q <= clr_cnt_q;
          write_data_q    <= '0;
          clr_cnt_q       <= clr_cnt_q + 1'b1;
          if (&clr_cnt_q) state_q <= IDLE;
        end
`ifdef REGFILE_ARB_LOCK_EN
        LOCKED: begin
          if (bus.clear_req) clear_pend_q <= 1'b1;
          if (acc) begin
            write_en_q      <= 1'b1;
            write_address_q <= req_addr_arr[acc_idx];
            write_data_q    <= req_data_arr[acc_idx];
            grant_id_q      <= acc_idx;
          end
          // Leave on an unlocked beat or when the owner stops requesting; a deferred
          // clear then starts straight away.
          if (!bus.req_valid[lock_id_q] || !bus.req_lock[lock_id_q]) begin
            if (clear_pend_q || bus.clear_req) begin
              state_q      <= CLEAR;
              clr_cnt_q    <= '0;
              clear_pend_q <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready     = ready;
  assign bus.clear_busy    = (state_q == CLEAR);
  assign bus.grant_id      = grant_id_q;
  assign bus.write_en      = write_en_q;
  assign bus.write_address = write_address_q;
  assign bus.write_data    = write_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized scoreboard bench for regfile_write_arbiter; the reference model follows
// REGFILE_ARB_LOCK_EN the same way the design does.
module tb_regfile_write_arbiter;
  import regfile_arb_pkg::*;

  localparam int N = 4;
`ifdef REGFILE_ARB_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  regfile_write_arbiter_if #(.NUM_REQ(N), .ADDR_W(REG_ADDR_W), .DATA_W(REG_DATA_W)) bus ();

  regfile_write_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (REG_ADDR_W),
    .DATA_W  (REG_DATA_W)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int due;
    int addr;
    int data;
    int gid;
    bit chk_gid;
  } exp_t;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  bit         chk_en = 1'b0;
  logic [3:0] exp_ready = '0;
  bit         exp_busy = 1'b0;

  // Reference model: pointer, lock owner (-1 none), deferred clear, pending clear addresses.
  int ptr = 0;
  int lock_owner = -1;
  bit clr_pend = 1'b0;
  int clr_todo[$];

  // Requester beats waiting for acceptance.
  bit    pend[N];
  addr_t paddr[N];
  data_t pdata[N];
  bit    plock[N];
  int    fill_pct[N];
  int    lock_left[N];
  bit    clear_in = 1'b0;

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic new_beat(input int i);
    pend[i]  = 1'b1;
    paddr[i] = addr_t'($urandom);
    pdata[i] = data_t'($urandom);
    plock[i] = (lock_left[i] > 0);
    if (lock_left[i] > 0) lock_left[i]--;
  endtask

  task automatic offer(input int i, input int a, input int d);
    pend[i]  = 1'b1;
    paddr[i] = addr_t'(a);
    pdata[i] = data_t'(d);
    plock[i] = 1'b0;
  endtask

  task automatic set_fill(input int pct);
    for (int i = 0; i < N; i++) fill_pct[i] = pct;
  endtask

  task automatic start_clear();
    for (int a = 0; a < NUM_ENTRIES; a++) clr_todo.push_back(a);
  endtask

  // One clock cycle: drive inputs, predict ready/busy and the write due next cycle.
  task automatic step();
    int acc;
    exp_t e;
    @(posedge clock);
    #1;
    cyc++;
    for (int i = 0; i < N; i++)
      if (!pend[i] && $urandom_range(99) < fill_pct[i]) new_beat(i);
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]               = pend[i];
      bus.req_lock[i]                = plock[i];
      bus.req_addr[i*REG_ADDR_W +: REG_ADDR_W] = paddr[i];
      bus.req_data[i*REG_DATA_W +: REG_DATA_W] = pdata[i];
    end
    bus.clear_req = clear_in;

    acc      = -1;
    exp_busy = (clr_todo.size() > 0);
    if (exp_busy) begin
      e = '{due: cyc + 1, addr: clr_todo.pop_front(), data: 0, gid: 0, chk_gid: 1'b0};
      exp_q.push_back(e);
    end else if (lock_owner >= 0) begin
      if (clear_in) clr_pend = 1'b1;
      if (pend[lock_owner]) begin
        acc = lock_owner;
        if (!plock[lock_owner]) lock_owner = -1;
      end else begin
        lock_owner = -1;
      end
      if (lock_owner < 0 && clr_pend) begin
        start_clear();
        clr_pend = 1'b0;
      end
    end else if (clear_in) begin
      start_clear();
    end else begin
      for (int k = 0; k < N; k++)
        if (acc < 0 && pend[(ptr + k) % N]) acc = (ptr + k) % N;
      if (acc >= 0) begin
        ptr = (acc + 1) % N;
        if (LockEn && plock[acc]) lock_owner = acc;
      end
    end

    exp_ready = '0;
    if (acc >= 0) begin
      exp_ready = 4'(1 << acc);
      e = '{due: cyc + 1, addr: int'(paddr[acc]), data: int'(pdata[acc]), gid: acc,
            chk_gid: 1'b1};
      exp_q.push_back(e);
      pend[acc] = 1'b0;
    end
    chk_en = 1'b1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic model_reset();
    ptr        = 0;
    lock_owner = -1;
    clr_pend   = 1'b0;
    clr_todo.delete();
    exp_q.delete();
    clear_in = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i]      = 1'b0;
      plock[i]     = 1'b0;
      lock_left[i] = 0;
      fill_pct[i]  = 0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " write_en"}, bus.write_en, 0);
    check({tag, " write_address"}, bus.write_address, 0);
    check({tag, " write_data"}, bus.write_data, 0);
    check({tag, " grant_id"}, bus.grant_id, 0);
    check({tag, " clear_busy"}, bus.clear_busy, 0);
    check({tag, " req_ready"}, bus.req_ready, 0);
  endtask

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clock) begin : mon
    exp_t e;
    if (chk_en && reset_n) begin
      check("req_ready", bus.req_ready, exp_ready);
      check("clear_busy", bus.clear_busy, exp_busy);
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        check("write_en", bus.write_en, 1);
        check("write_address", bus.write_address, e.addr);
        check("write_data", bus.write_data, e.data);
        if (e.chk_gid) check("grant_id", bus.grant_id, e.gid);
      end else begin
        check("write_en idle", bus.write_en, 0);
      end
    end
  end

  initial begin
    model_reset();
    bus.req_valid = '1;
    bus.req_lock  = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.clear_req = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    bus.req_valid = '0;
    #2 reset_n = 1'b1;

    // Fairness from ptr 0: all requesters continuously valid.
    set_fill(100);
    steps(6);
    set_fill(0);
    steps(6);

    // Single requester.
    offer(1, 2, 8'h5A);
    steps(3);

    // Clear pre-empts a same-cycle request.
    offer(0, 1, 8'hC3);
    clear_in = 1'b1;
    step();
    clear_in = 1'b0;
    steps(8);

    // Wrap/skip: bring ptr to 1, then only req3 and req0.
    offer(0, 3, 8'h11);
    steps(2);
    offer(3, 0, 8'h33);
    offer(0, 0, 8'h44);
    steps(4);

    // Lock: req2 asks for three locked beats while everyone is busy.
    lock_left[2] = 3;
    set_fill(100);
    steps(10);
    set_fill(0);
    steps(6);

    // Randomized traffic with clears and locks.
    for (int blk = 0; blk < 20; blk++) begin
      for (int i = 0; i < N; i++) begin
        fill_pct[i] = $urandom_range(100);
        if ($urandom_range(3) == 0) lock_left[i] = $urandom_range(3);
      end
      for (int c = 0; c < 20; c++) begin
        clear_in = ($urandom_range(24) == 0);
        step();
      end
    end
    clear_in = 1'b0;
    set_fill(0);
    steps(8);

    // Reset while a write is on the port.
    offer(1, 3, 8'hA5);
    step();
    @(posedge clock);
    #2;
    chk_en = 1'b0;
    check("pre-reset write_en", bus.write_en, 1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid reset");
    model_reset();
    bus.req_valid = '0;
    bus.clear_req = 1'b0;
    @(posedge clock);
    #3 reset_n = 1'b1;
    set_fill(100);
    steps(6);
    set_fill(0);
    steps(6);

    chk_en = 1'b0;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover expected writes: got %0d expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
